// File: rtl/adder_tree_ctrl.sv
// PSUM adder-tree sequencer: one PSUM handshake per pass, then serialises the tree result as 32b words.
// Optional ADDER_TREE_CTRL_STALL_CNT_EN adds a saturating output-stall counter on port stall_cnt.
`timescale 1ns/1ps
module adder_tree_ctrl #(
  parameter int PASS_W = 8,
  parameter int OUT_W  = 32,
  parameter int RES_W  = 288
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_start,
  input  logic [1:0]        cfg_mode,
  input  logic [PASS_W-1:0] cfg_num_pass,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  input  logic              psum_valid,
  output logic              psum_ready,
  output logic [1:0]        at_mode,
  input  logic [RES_W-1:0]  at_res,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_last
`ifdef ADDER_TREE_CTRL_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_CAP,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          mode_q;
  logic [PASS_W-1:0]   pass_q;
  logic [RES_W-1:0]    buf_q;
  logic [3:0]          idx_q;
  logic                err_q;
  logic [3:0]          last_idx;
  logic                word_last;
  logic                start_legal;
  logic                start_illegal;

  assign start_legal   = (state_q == S_IDLE) && cfg_start && (cfg_mode != 2'b11);
  assign start_illegal = (state_q == S_IDLE) && cfg_start && (cfg_mode == 2'b11);

  // Index of the last 32b word in a pass: 1, 3 or 9 words per pass.
  always_comb begin
    last_idx = 4'd8;
    case (mode_q)
      2'b00:   last_idx = 4'd0;
      2'b01:   last_idx = 4'd2;
      default: last_idx = 4'd8;
    endcase
  end

  assign word_last = (idx_q == last_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_legal) state_d = (cfg_num_pass == '0) ? S_DONE : S_REQ;
      S_REQ:   if (psum_valid) state_d = S_WAIT;
      S_WAIT:  state_d = S_CAP;
      S_CAP:   state_d = S_DRAIN;
      S_DRAIN: if (out_ready && word_last) state_d = (pass_q == '0) ? S_DONE : S_REQ;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // busy covers the accepting start cycle itself, so it rises together with the strobe.
  assign busy       = (state_q != S_IDLE) || start_legal;
  assign done       = (state_q == S_DONE);
  assign psum_ready = (state_q == S_REQ);
  assign out_valid  = (state_q == S_DRAIN);
  assign out_last   = (state_q == S_DRAIN) && word_last && (pass_q == '0);
  assign out_data   = buf_q[{idx_q, 5'b00000} +: OUT_W];
  assign at_mode    = mode_q;
  assign cfg_err    = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= 2'b00;
      pass_q <= '0;
      buf_q  <= '0;
      idx_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      if (start_legal) begin
        mode_q <= cfg_mode;
        pass_q <= cfg_num_pass;
        err_q  <= 1'b0;
      end else if (start_illegal) begin
        err_q  <= 1'b1;
      end
      if (state_q == S_CAP) begin
        buf_q <= at_res;
        idx_q <= '0;
        if (pass_q != '0) pass_q <= pass_q - 1'b1;
      end
      if ((state_q == S_DRAIN) && out_ready && !word_last) idx_q <= idx_q + 1'b1;
    end
  end

`ifdef ADDER_TREE_CTRL_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                                    stall_cnt <= '0;
    else if (start_legal)                                          stall_cnt <= '0;
    else if ((state_q == S_DRAIN) && !out_ready && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 1'b1;
  end
`endif

endmodule
